// File: rtl/apb_mem_completer.sv
// APB3 completer with a word-addressed memory array.
// Adds programmable wait states and an error response for bad addresses.
module apb_mem_completer #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 256,
  parameter int                    WAIT_CYCLES = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH * 4);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_err;
  logic                  setup;
  logic                  access;
  logic                  done;
  logic                  mem_we;

  assign offset  = paddr_i - BASE_ADDR;
  assign dec_idx = offset[IDX_W+1:2];
  assign dec_err = (paddr_i < BASE_ADDR)
                 | ({1'b0, offset} >= LIMIT)
                 | (paddr_i[1:0] != 2'b00);

  assign setup  = psel_i & ~penable_i;
  assign access = psel_i & penable_i;
  assign done   = (state_q == ACCESS) & access
                & (cnt_q == 4'd0);
  assign mem_we = done & write_q & ~err_q & ~rst;

  // Next-state: a setup phase (re)loads the transfer in either state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    write_d = write_q;
    err_d   = err_q;
    if (setup) begin
      state_d = ACCESS;
      cnt_d   = 4'(WAIT_CYCLES);
      addr_d  = dec_idx;
      wdata_d = pwdata_i;
      write_d = pwrite_i;
      err_d   = dec_err;
      rdata_d = dec_err ? '0 : mem[dec_idx];
    end else if (state_q == ACCESS) begin
      if (!psel_i) begin
        state_d = IDLE;
      end else if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Transfer state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Array write on the completion edge of a good write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign pready_o  = (state_q == ACCESS) & (cnt_q == 4'd0);
  assign pslverr_o = pready_o & err_q;
  assign prdata_o  = (pready_o & ~write_q & ~err_q)
                   ? rdata_q : '0;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: table of per-cycle vectors plus
// hand-built abort, mid-access reset and zero-wait sequences.
module tb_apb_mem_completer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        psel_a = 0, pen_a = 0, pwr_a = 0;
  logic [31:0] paddr_a = 0, pwdata_a = 0, prdata_a;
  logic        prdy_a, perr_a;

  logic        psel_b = 0, pen_b = 0, pwr_b = 0;
  logic [31:0] paddr_b = 0, pwdata_b = 0, prdata_b;
  logic        prdy_b, perr_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_mem_completer #(.WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .psel_i(psel_a), .penable_i(pen_a), .pwrite_i(pwr_a),
    .paddr_i(paddr_a), .pwdata_i(pwdata_a),
    .prdata_o(prdata_a), .pready_o(prdy_a), .pslverr_o(perr_a)
  );

  apb_mem_completer #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .psel_i(psel_b), .penable_i(pen_b), .pwrite_i(pwr_b),
    .paddr_i(paddr_b), .pwdata_i(pwdata_b),
    .prdata_o(prdata_b), .pready_o(prdy_b), .pslverr_o(perr_b)
  );

  typedef struct {
    logic        r, s, e, w;
    logic [31:0] a, d;
    logic        er, ee;
    logic [31:0] ed;
    bit [95:0]   nm;
  } vec_t;

  vec_t tbl[$];

  // One cycle: drive, sample at negedge, advance to just past posedge.
  task automatic step(input bit b, input logic r, s, e, w,
                      input logic [31:0] a, d,
                      input logic er, ee, input logic [31:0] ed,
                      input bit [95:0] nm);
    logic        ar, ae;
    logic [31:0] ad;
    rst = r;
    if (!b) begin
      psel_a = s; pen_a = e; pwr_a = w; paddr_a = a; pwdata_a = d;
    end else begin
      psel_b = s; pen_b = e; pwr_b = w; paddr_b = a; pwdata_b = d;
    end
    @(negedge clk);
    ar = b ? prdy_b : prdy_a;
    ae = b ? perr_b : perr_a;
    ad = b ? prdata_b : prdata_a;
    checks++;
    if (ar !== er || ae !== ee || ad !== ed) begin
      errors++;
      $display("FAIL %0s: got rdy=%b err=%b data=%h, want rdy=%b err=%b data=%h",
               nm, ar, ae, ad, er, ee, ed);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, s, e, w, input logic [31:0] a, d,
                     input logic er, ee, input logic [31:0] ed,
                     input bit [95:0] nm);
    vec_t v;
    v.r = r; v.s = s; v.e = e; v.w = w; v.a = a; v.d = d;
    v.er = er; v.ee = ee; v.ed = ed; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Wait-2 transfer; access-phase inputs are scrambled and must be ignored.
  task automatic add_xfer(input logic w, input logic [31:0] a, d,
                          input logic ee, input logic [31:0] ed,
                          input bit [95:0] nm);
    add(0, 1, 0, w, a, d, 0, 0, 0, nm);
    add(0, 1, 1, ~w, a ^ 32'h40, ~d, 0, 0, 0, nm);
    add(0, 1, 1, ~w, a ^ 32'h40, ~d, 0, 0, 0, nm);
    add(0, 1, 1, ~w, a ^ 32'h40, ~d, 1, ee, w ? 32'h0 : ed, nm);
  endtask

  task automatic do_xfer(input bit b, input logic w,
                         input logic [31:0] a, d,
                         input logic ee, input logic [31:0] ed,
                         input bit [95:0] nm);
    int n;
    n = b ? 0 : 2;
    step(b, 0, 1, 0, w, a, d, 0, 0, 0, nm);
    for (int i = 0; i < n; i++)
      step(b, 0, 1, 1, w, a, d, 0, 0, 0, nm);
    step(b, 0, 1, 1, w, a, d, 1, ee, w ? 32'h0 : ed, nm);
  endtask

  initial begin
    add(1, 1, 0, 0, 32'h10, 0, 0, 0, 0, "rst0");
    add(1, 1, 0, 0, 32'h10, 0, 0, 0, 0, "rst1");
    add(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, "rel");
    add_xfer(1, 32'h10, 32'hDEAD_BEEF, 0, 0, "w10");
    add_xfer(0, 32'h10, 0, 0, 32'hDEAD_BEEF, "r10");
    add_xfer(1, 32'h0, 32'h1111_1111, 0, 0, "w0");
    add_xfer(1, 32'h4, 32'h2222_2222, 0, 0, "w4");
    add_xfer(1, 32'h8, 32'h3333_3333, 0, 0, "w8");
    add_xfer(1, 32'h3FC, 32'hCAFE_F00D, 0, 0, "w3fc");
    add_xfer(1, 32'h400, 32'hAAAA_AAAA, 1, 0, "w400");
    add_xfer(1, 32'h6, 32'hBBBB_BBBB, 1, 0, "w6");
    add_xfer(0, 32'h0, 0, 0, 32'h1111_1111, "r0");
    add_xfer(0, 32'h4, 0, 0, 32'h2222_2222, "r4");
    add_xfer(0, 32'h400, 0, 1, 0, "r400");
    add_xfer(0, 32'h6, 0, 1, 0, "r6");
    add_xfer(0, 32'h3FC, 0, 0, 32'hCAFE_F00D, "r3fc");

    @(posedge clk);
    #1;
    foreach (tbl[i])
      step(0, tbl[i].r, tbl[i].s, tbl[i].e, tbl[i].w,
           tbl[i].a, tbl[i].d, tbl[i].er, tbl[i].ee,
           tbl[i].ed, tbl[i].nm);

    step(0, 0, 1, 0, 1, 32'h8, 32'hAAAA_5555, 0, 0, 0, "ab_setup");
    step(0, 0, 0, 0, 1, 32'h8, 32'hAAAA_5555, 0, 0, 0, "ab_drop");
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 1, 1, 32'h8, 32'hAAAA_5555, 0, 0, 0, "ab_idle");
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, "ab_gap");
    do_xfer(0, 0, 32'h8, 0, 0, 32'h3333_3333, "ab_r8");

    step(0, 0, 1, 0, 1, 32'h10, 32'h5555_5555, 0, 0, 0, "rs_setup");
    step(0, 0, 1, 1, 1, 32'h10, 32'h5555_5555, 0, 0, 0, "rs_a1");
    step(0, 1, 1, 1, 1, 32'h10, 32'h5555_5555, 0, 0, 0, "rs_a2");
    step(0, 0, 1, 1, 1, 32'h10, 32'h5555_5555, 0, 0, 0, "rs_post");
    step(0, 0, 1, 1, 1, 32'h10, 32'h5555_5555, 0, 0, 0, "rs_post2");
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, "rs_gap");
    do_xfer(0, 0, 32'h10, 0, 0, 32'hDEAD_BEEF, "rs_r10");
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, "a_park");

    do_xfer(1, 1, 32'h4, 32'h1234_5678, 0, 0, "z_w4");
    do_xfer(1, 0, 32'h4, 0, 0, 32'h1234_5678, "z_r4");
    do_xfer(1, 1, 32'h8, 32'h0BAD_F00D, 0, 0, "z_w8");
    do_xfer(1, 0, 32'h8, 0, 0, 32'h0BAD_F00D, "z_r8");
    do_xfer(1, 0, 32'h404, 0, 1, 0, "z_r404");
    step(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, "z_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
